// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch unit: pc to imem req/ack, registered inst to decode valid/ready
module instruction_fetch #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              pc_en,
    output logic              fetch_err
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, REQ, HOLD, DROP, ERR} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;

    assign waiting = (state == REQ) || (state == DROP);
    // Fires on the WAIT_MAX-th consecutive cycle of req without ack.
    assign timeout = waiting && !imem_ack && (wait_cnt == CNT_W'(WAIT_MAX - 1));
    assign pc_en   = (state == HOLD) && inst_ready && !flush;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!flush) state_next = REQ;
            REQ: begin
                if (timeout)       state_next = ERR;
                else if (imem_ack) state_next = flush ? IDLE : HOLD;
                else if (flush)    state_next = DROP;
            end
            DROP: begin
                if (timeout)       state_next = ERR;
                else if (imem_ack) state_next = IDLE;
            end
            HOLD: if (flush || inst_ready) state_next = IDLE;
            ERR:  state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            fetch_err  <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (!flush) begin
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        wait_cnt  <= '0;
                    end
                end
                REQ, DROP: begin
                    if (timeout) begin
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        // Data returned for a flushed fetch is dropped on the floor.
                        if (state == REQ && !flush) begin
                            inst       <= imem_rdata;
                            inst_pc    <= imem_addr;
                            inst_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HOLD: if (flush || inst_ready) inst_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch unit between program_counter (pc source) and the instruction memory port.
- Takes the current pc and issues a read request with a req/ack handshake.
- Registers the returned word and presents it to decode under a valid/ready handshake.
- Drives pc_en, which qualifies the next_pc mux, so pc advances only when decode accepts an instruction. Supports flush (branch redirect) and a memory-timeout error.

Parameters:
- ADDR_W, 32, width of pc and memory address
- DATA_W, 32, instruction width
- WAIT_MAX, 15, max cycles req may stay high without ack before error

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- pc  input  ADDR_W  current pc from program_counter
- flush  input  1  discard current/in-flight fetch (pc being redirected)
- imem_req  output  1  memory read request
- imem_addr  output  ADDR_W  read address, registered
- imem_ack  input  1  read data valid this cycle
- imem_rdata  input  DATA_W  read data
- inst_valid  output  1  inst/inst_pc valid for decode
- inst  output  DATA_W  fetched instruction
- inst_pc  output  ADDR_W  address of inst
- inst_ready  input  1  decode accepts inst this cycle
- pc_en  output  1  combinational; high = next_pc mux selects pc+4 this edge
- fetch_err  output  1  sticky timeout flag

Behaviour:
- Reset (async, immediate):
  - state=IDLE
  - imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, wait counter=0.
- States: IDLE, REQ, HOLD, DROP, ERR.
- IDLE:
  - flush=0: at edge imem_addr<=pc, imem_req<=1, counter<=0, go REQ.
  - flush=1: stay IDLE.
- REQ:
  - imem_req=1 and imem_addr held stable until ack.
  - ack & !flush: inst<=imem_rdata, inst_pc<=imem_addr, inst_valid<=1, imem_req<=0, go HOLD.
  - flush (with or without ack): go DROP if no ack, IDLE if ack; data discarded, inst_valid stays 0.
  - No ack: counter++.
- DROP:
  - imem_req stays 1 until ack; rdata discarded; go IDLE on ack.
  - Counter runs as in REQ.
- HOLD:
  - inst_valid=1; inst and inst_pc stable.
  - inst_ready & !flush: handshake; at edge inst_valid<=0, go IDLE.
  - flush: inst_valid<=0, go IDLE, no pc_en.
- pc_en = (state==HOLD) & inst_ready & !flush. program_counter latches pc+4 at that same edge; IDLE samples the new pc one edge later. Min latency pc -> inst_valid = 2 cycles (IDLE edge, ack cycle edge with 0-wait ack); throughput 1 instr per 3 cycles with 0-wait memory and ready=1.
- Timeout: counter reaching WAIT_MAX with no ack in REQ or DROP sets fetch_err<=1, imem_req<=0, go ERR.
- ERR: absorbing; no requests, inst_valid=0; exit only by rst.
- Ack outside REQ/DROP is ignored.
- Reset mid-transaction: all outputs return to reset values immediately, in-flight ack ignored.
- Flush and inst_ready together in HOLD: flush wins, pc_en=0.

Test Plan:
- Reset: rst=1 with pc=0x0000_0040 -> all outputs 0; after release, 1 cycle later imem_req=1, imem_addr=0x40.
- Zero-wait fetch: pc=0x0, ack same cycle as req with rdata=0xDEAD_BEEF, inst_ready=1:
  - inst_valid=1, inst=0xDEAD_BEEF, inst_pc=0x0, pc_en=1 for that cycle.
  - Next req has imem_addr=0x4.
- Backpressure: inst_ready=0 for 4 cycles -> inst_valid held, inst stable, pc_en=0, imem_req=0; raise ready -> single pc_en pulse.
- Wait states: ack delayed 3 cycles -> imem_addr stable throughout; inst captured only on ack cycle.
- Flush in REQ: flush one cycle, ack 2 cycles later with 0x1111_1111 -> inst_valid never 1; next request uses redirected pc 0x0000_0100.
- Timeout: no ack for WAIT_MAX=15 cycles -> fetch_err=1, imem_req=0; further acks ignored; rst clears it.
